// File: rtl/sensor_packet_framer.sv
// sensor_packet_framer
//   Buffers sensor payload bytes and frames them for the radio as
//   PREAMBLE, SYNC, NODE_ID, LEN, payload[0..LEN-1], CHECKSUM.
//   The checksum is the XOR of NODE_ID, LEN and every payload byte. It is
//   accumulated as those bytes are emitted.
//
// Ports
//   clk, rst_n        clock; synchronous active-low reset
//   enable            low aborts any frame and clears the block, like reset
//   s_valid/s_data    payload byte in; s_ready is the acceptance qualifier
//   flush             one-cycle request to frame a partial, non-empty buffer
//   radio_tx_data     byte to radio, stable from the send strobe until the next load
//   radio_send        one-cycle send strobe
//   radio_busy        radio busy transmitting
//   frame_active      high from the first header byte load until frame_done
//   frame_done        one-cycle pulse after the checksum byte completes
//   overflow          one-cycle pulse per dropped payload byte
//   tmo_err           sticky: busy failed to rise within BUSY_TMO cycles
//   dbg_state         current FSM state, for observation only
//
// Handshakes
//   Payload in: a byte transfers on each cycle where s_valid && s_ready are
//   both high. If s_valid is high with s_ready low while enabled, the byte
//   is dropped and overflow pulses.
//   Radio out: the radio_send strobe is only issued when radio_busy is low.
//   The radio must then raise busy and later drop it. Dropping busy marks
//   the byte as done.

module sensor_packet_framer #(
  parameter logic [7:0]  NODE_ID  = 8'h01,
  parameter int unsigned MAX_LEN  = 8,
  parameter logic [7:0]  PREAMBLE = 8'hAA,
  parameter logic [7:0]  SYNC     = 8'h7E,
  parameter int unsigned BUSY_TMO = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  output logic       s_ready,
  input  logic       flush,
  output logic [7:0] radio_tx_data,
  output logic       radio_send,
  input  logic       radio_busy,
  output logic       frame_active,
  output logic       frame_done,
  output logic       overflow,
  output logic       tmo_err,
  output logic [2:0] dbg_state
);

  localparam int CW = $clog2(MAX_LEN + 6);
  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TW = $clog2(BUSY_TMO + 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_SEND    = 3'd2,
    ST_WAIT_HI = 3'd3,
    ST_WAIT_LO = 3'd4,
    ST_NEXT    = 3'd5,
    ST_DONE    = 3'd6
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   idx_q, idx_d;
  logic [7:0]      len_q, len_d;
  logic [7:0]      chk_q, chk_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            frame_active_q, frame_active_d;
  logic            tmo_err_q, tmo_err_d;
  logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
  logic [7:0]      buf_q [0:(1<<AW)-1];

  logic            wr_en;
  logic [CW-1:0]   count_after;
  logic [CW-1:0]   last_idx;
  logic [7:0]      cur_byte;

  assign s_ready       = enable && (state_q == ST_IDLE) && (count_q < CW'(MAX_LEN));
  assign wr_en         = s_valid && s_ready;
  assign overflow      = s_valid && !s_ready && enable;
  assign count_after   = count_q + CW'(wr_en);
  // Index of the checksum byte: four header bytes precede the payload.
  assign last_idx      = CW'(len_q) + CW'(4);

  assign radio_send    = (state_q == ST_SEND);
  assign frame_done    = (state_q == ST_DONE);
  assign radio_tx_data = tx_data_q;
  assign frame_active  = frame_active_q;
  assign tmo_err       = tmo_err_q;
  assign dbg_state     = state_q;

  // Byte selected by the frame position.
  always_comb begin
    cur_byte = 8'h00;
    if (idx_q == CW'(0))       cur_byte = PREAMBLE;
    else if (idx_q == CW'(1))  cur_byte = SYNC;
    else if (idx_q == CW'(2))  cur_byte = NODE_ID;
    else if (idx_q == CW'(3))  cur_byte = len_q;
    else if (idx_q == last_idx) cur_byte = chk_q;
    else                       cur_byte = buf_q[AW'(idx_q - CW'(4))];
  end

  always_comb begin
    state_d        = state_q;
    count_d        = count_q;
    idx_d          = idx_q;
    len_d          = len_q;
    chk_d          = chk_q;
    tx_data_d      = tx_data_q;
    frame_active_d = frame_active_q;
    tmo_err_d      = tmo_err_q;
    tmo_cnt_d      = tmo_cnt_q;

    case (state_q)
      ST_IDLE: begin
        count_d = count_after;
        // A byte written this cycle counts toward the trigger, so a byte
        // that arrives with flush, or that fills the buffer, is framed.
        if ((count_after == CW'(MAX_LEN)) || (flush && (count_after != '0))) begin
          len_d   = 8'(count_after);
          idx_d   = '0;
          chk_d   = 8'h00;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        tx_data_d      = cur_byte;
        frame_active_d = 1'b1;
        if (!radio_busy) state_d = ST_SEND;
      end
      ST_SEND: begin
        tmo_cnt_d = '0;
        state_d   = ST_WAIT_HI;
      end
      ST_WAIT_HI: begin
        if (radio_busy) begin
          state_d = ST_WAIT_LO;
        end else if (tmo_cnt_q == TW'(BUSY_TMO - 1)) begin
          // The radio never acknowledged. The byte is treated as sent so
          // the frame still completes and no byte is repeated.
          tmo_err_d = 1'b1;
          state_d   = ST_NEXT;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
      end
      ST_WAIT_LO: begin
        if (!radio_busy) state_d = ST_NEXT;
      end
      ST_NEXT: begin
        // Fold NODE_ID, LEN and the payload into the checksum once each is out.
        if ((idx_q >= CW'(2)) && (idx_q < last_idx)) chk_d = chk_q ^ tx_data_q;
        if (idx_q == last_idx) begin
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + CW'(1);
          state_d = ST_LOAD;
        end
      end
      ST_DONE: begin
        frame_active_d = 1'b0;
        count_d        = '0;
        idx_d          = '0;
        chk_d          = 8'h00;
        tx_data_d      = 8'h00;
        state_d        = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // A low enable drops everything, including a partial frame.
    if (!enable) begin
      state_d        = ST_IDLE;
      count_d        = '0;
      idx_d          = '0;
      len_d          = 8'h00;
      chk_d          = 8'h00;
      tx_data_d      = 8'h00;
      frame_active_d = 1'b0;
      tmo_err_d      = 1'b0;
      tmo_cnt_d      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      count_q        <= '0;
      idx_q          <= '0;
      len_q          <= 8'h00;
      chk_q          <= 8'h00;
      tx_data_q      <= 8'h00;
      frame_active_q <= 1'b0;
      tmo_err_q      <= 1'b0;
      tmo_cnt_q      <= '0;
    end else begin
      state_q        <= state_d;
      count_q        <= count_d;
      idx_q          <= idx_d;
      len_q          <= len_d;
      chk_q          <= chk_d;
      tx_data_q      <= tx_data_d;
      frame_active_q <= frame_active_d;
      tmo_err_q      <= tmo_err_d;
      tmo_cnt_q      <= tmo_cnt_d;
    end
  end

  // Payload storage. The data needs no reset because count gates every read.
  always_ff @(posedge clk) begin
    if (wr_en) buf_q[AW'(count_q)] <= s_data;
  end

endmodule
